// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory access unit: FSM states, request op and
// the active-low request strobe level.
package dmem_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // DmemREB/DmemWEB request when driven to this level
    localparam logic REQ_ACTIVE = 1'b0;

endpackage

// File: rtl/dmem_ram_sp.sv
// Single-port synchronous word RAM with a registered, read-enabled output.
// Kept separate so the array can be replaced by a vendor macro.
module dmem_ram_sp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Output register holds the last read until the next read enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Data-memory responder: captures one word read/write request, waits WAIT_CYCLES,
// accesses the RAM, and stalls the pipeline while the request is in flight.
//
// state  | meaning
// IDLE   | waiting for a request; legal ones are captured, illegal ones flagged
// WAIT   | counting down programmable wait states
// ACCESS | RAM read or write performed on the closing edge
// DONE   | stall released for one cycle; any request present is ignored
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 10,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              DmemREB,
    input  logic              DmemWEB,
    input  logic [31:0]       Addr,
    input  logic [DATA_W-1:0] WData,
    output logic [DATA_W-1:0] RData,
    output logic              RValid,
    output logic              Stall,
    output logic              ErrMisalign,
    output logic              ErrConflict
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                state;
    op_t                   op;
    logic [3:0]            cnt;
    logic [DEPTH_LOG2-1:0] idx;
    logic [DATA_W-1:0]     wdata_q;

    logic req_rd;
    logic req_wr;
    logic conflict;
    logic one_req;
    logic misalign;
    logic legal;
    logic ram_we;
    logic ram_re;
    logic unused_addr;

    assign req_rd   = (DmemREB == REQ_ACTIVE);
    assign req_wr   = (DmemWEB == REQ_ACTIVE);
    assign conflict = req_rd & req_wr;
    assign one_req  = req_rd ^ req_wr;
    assign misalign = (Addr[1:0] != 2'b00);
    assign legal    = one_req & ~misalign;

    // Upper address bits wrap: only the word index within the RAM is used.
    assign unused_addr = ^Addr[31:DEPTH_LOG2+2];

    // Gated by rst so every output reads zero while reset is held.
    assign Stall = ~rst & (((state == S_IDLE) & legal) |
                           (state == S_WAIT) | (state == S_ACCESS));

    assign ram_we = (state == S_ACCESS) & (op == OP_WR);
    assign ram_re = (state == S_ACCESS) & (op == OP_RD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            op          <= OP_RD;
            cnt         <= 4'd0;
            idx         <= '0;
            wdata_q     <= '0;
            RValid      <= 1'b0;
            ErrMisalign <= 1'b0;
            ErrConflict <= 1'b0;
        end else begin
            RValid      <= ram_re;
            ErrConflict <= (state == S_IDLE) & conflict;
            ErrMisalign <= (state == S_IDLE) & one_req & misalign;
            case (state)
                S_IDLE: begin
                    if (legal) begin
                        op      <= req_wr ? OP_WR : OP_RD;
                        idx     <= Addr[DEPTH_LOG2+1:2];
                        wdata_q <= WData;
                        cnt     <= WAIT_LOAD;
                        state   <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= S_ACCESS;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACCESS: state <= S_DONE;
                S_DONE:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    dmem_ram_sp #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (idx),
        .wdata (wdata_q),
        .rdata (RData)
    );

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: unit 0 built with no wait states,
// unit 1 with two; a vector table plus a hand-written reset-abort sequence.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reb   [2];
    logic        web   [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata [2];
    logic        rvalid[2];
    logic        stall [2];
    logic        errm  [2];
    logic        errc  [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.DEPTH_LOG2(10), .WAIT_CYCLES(0), .DATA_W(32)) u_w0 (
        .clk(clk), .rst(rst), .DmemREB(reb[0]), .DmemWEB(web[0]), .Addr(addr[0]),
        .WData(wdata[0]), .RData(rdata[0]), .RValid(rvalid[0]), .Stall(stall[0]),
        .ErrMisalign(errm[0]), .ErrConflict(errc[0]));

    dmem_access_unit #(.DEPTH_LOG2(10), .WAIT_CYCLES(2), .DATA_W(32)) u_w2 (
        .clk(clk), .rst(rst), .DmemREB(reb[1]), .DmemWEB(web[1]), .Addr(addr[1]),
        .WData(wdata[1]), .RData(rdata[1]), .RValid(rvalid[1]), .Stall(stall[1]),
        .ErrMisalign(errm[1]), .ErrConflict(errc[1]));

    typedef struct {
        int          stall_n;
        int          rv_at;
        int          rv_n;
        int          em_n;
        int          ec_n;
        logic [31:0] rd_end;
    } res_t;

    typedef struct {
        int          u;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] d;
        int          exp_stall;
        int          exp_rv_at;
        int          exp_rv_n;
        int          exp_em;
        int          exp_ec;
        logic [31:0] exp_rd;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a request and hold it until Stall drops; the pipeline advances on
    // the edge after that, so the request is still present through DONE.
    task automatic txn(input int u, input bit rd, input bit wr,
                       input logic [31:0] a, input logic [31:0] d, output res_t r);
        bit released = 1'b0;
        r.stall_n = 0; r.rv_at = -1; r.rv_n = 0; r.em_n = 0; r.ec_n = 0; r.rd_end = '0;
        @(negedge clk);
        reb[u] = !rd; web[u] = !wr; addr[u] = a; wdata[u] = d;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (stall[u]) r.stall_n++;
            if (rvalid[u]) begin
                if (r.rv_at < 0) r.rv_at = c;
                r.rv_n++;
            end
            if (errm[u]) r.em_n++;
            if (errc[u]) r.ec_n++;
            if (!stall[u] && !released) begin
                @(posedge clk);
                #1;
                reb[u] = 1'b1; web[u] = 1'b1;
                released = 1'b1;
            end
            @(negedge clk);
        end
        r.rd_end = rdata[u];
    endtask

    vec_t vecs[13];
    res_t r;

    initial begin
        for (int u = 0; u < 2; u++) begin
            reb[u] = 1'b1; web[u] = 1'b1; addr[u] = '0; wdata[u] = '0;
        end

        // unit 1, W=2: table entries follow the hand-written reset sequence
        vecs[0]  = '{1, 0, 1, 32'h40,   32'h12345678, 4, -1, 0, 0, 0, 32'hDEADBEEF};
        vecs[1]  = '{1, 1, 0, 32'h40,   32'h0,        4,  4, 1, 0, 0, 32'h12345678};
        vecs[2]  = '{1, 0, 1, 32'h1000, 32'hCAFEF00D, 4, -1, 0, 0, 0, 32'h12345678};
        vecs[3]  = '{1, 1, 0, 32'h0,    32'h0,        4,  4, 1, 0, 0, 32'hCAFEF00D};
        vecs[4]  = '{1, 1, 1, 32'h42,   32'hFFFFFFFF, 0, -1, 0, 0, 1, 32'hCAFEF00D};
        vecs[5]  = '{1, 1, 0, 32'h40,   32'h0,        4,  4, 1, 0, 0, 32'h12345678};
        vecs[6]  = '{1, 0, 1, 32'h42,   32'h00000BAD, 0, -1, 0, 1, 0, 32'h12345678};
        vecs[7]  = '{1, 1, 0, 32'h40,   32'h0,        4,  4, 1, 0, 0, 32'h12345678};
        vecs[8]  = '{1, 0, 1, 32'h8,    32'h1,        4, -1, 0, 0, 0, 32'h12345678};
        vecs[9]  = '{1, 1, 0, 32'h8,    32'h0,        4,  4, 1, 0, 0, 32'h00000001};
        // unit 0, W=0
        vecs[10] = '{0, 0, 1, 32'h0,    32'hA5A5A5A5, 2, -1, 0, 0, 0, 32'h0};
        vecs[11] = '{0, 1, 0, 32'h0,    32'h0,        2,  2, 1, 0, 0, 32'hA5A5A5A5};
        vecs[12] = '{0, 1, 0, 32'h1000, 32'h0,        2,  2, 1, 0, 0, 32'hA5A5A5A5};

        // reset state
        repeat (2) @(negedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk("rst_rdata",  rdata[u],  32'h0);
            chk("rst_rvalid", 32'(rvalid[u]), 32'h0);
            chk("rst_stall",  32'(stall[u]),  32'h0);
            chk("rst_errm",   32'(errm[u]),   32'h0);
            chk("rst_errc",   32'(errc[u]),   32'h0);
        end
        @(negedge clk);
        rst = 1'b0;

        // preload 0x10, read it back so RData is non-zero before the abort
        txn(1, 0, 1, 32'h10, 32'hDEADBEEF, r);
        chk("pre_wr_stall", 32'(r.stall_n), 32'd4);
        txn(1, 1, 0, 32'h10, 32'h0, r);
        chk("pre_rd_data", r.rd_end, 32'hDEADBEEF);

        // write to 0x10 aborted by reset while in WAIT
        @(negedge clk);
        reb[1] = 1'b1; web[1] = 1'b0; addr[1] = 32'h10; wdata[1] = 32'h0BADF00D;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_stall",  32'(stall[1]),  32'h0);
        chk("abort_rvalid", 32'(rvalid[1]), 32'h0);
        chk("abort_rdata",  rdata[1],       32'h0);
        chk("abort_errm",   32'(errm[1]),   32'h0);
        chk("abort_errc",   32'(errc[1]),   32'h0);
        @(negedge clk);
        web[1] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        txn(1, 1, 0, 32'h10, 32'h0, r);
        chk("abort_rd_data",  r.rd_end,        32'hDEADBEEF);
        chk("abort_rd_rv_at", 32'(r.rv_at),    32'd4);

        for (int i = 0; i < 13; i++) begin
            txn(vecs[i].u, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, r);
            chk($sformatf("v%0d_stall", i), 32'(r.stall_n), 32'(vecs[i].exp_stall));
            chk($sformatf("v%0d_rv_at", i), 32'(r.rv_at),   32'(vecs[i].exp_rv_at));
            chk($sformatf("v%0d_rv_n", i),  32'(r.rv_n),    32'(vecs[i].exp_rv_n));
            chk($sformatf("v%0d_errm", i),  32'(r.em_n),    32'(vecs[i].exp_em));
            chk($sformatf("v%0d_errc", i),  32'(r.ec_n),    32'(vecs[i].exp_ec));
            chk($sformatf("v%0d_rdata", i), r.rd_end,       vecs[i].exp_rd);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
Data-memory responder at the far end of the DmemREB/DmemWEB request interface driven by the control unit in the EX stage.
- Accepts one word read or write per request and services it against an internal word-addressed RAM after a programmable number of wait states.
- Holds the pipeline with Stall while the request is in flight.
- Returns load data with a one-cycle valid pulse and flags illegal requests.

Parameters:
DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words)
WAIT_CYCLES, 2, wait states between request capture and RAM access; legal range 0..15
DATA_W, 32, data width; fixed at 32, word accesses only

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
DmemREB  in  1  read request, active-low
DmemWEB  in  1  write request, active-low
Addr  in  32  byte address from ALU output
WData  in  32  store data
RData  out  32  load data, held until the next completed read
RValid  out  1  one-cycle pulse when RData is updated
Stall  out  1  high while a request is pending; the pipeline freezes Addr/WData/REB/WEB while Stall is high
ErrMisalign  out  1  one-cycle pulse: Addr[1:0] != 0 on a request
ErrConflict  out  1  one-cycle pulse: DmemREB and DmemWEB both low

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, wait counter=0, RData=0, RValid=0, ErrMisalign=0, ErrConflict=0. RAM contents are not reset.
- Stall is combinational: high in IDLE when a legal request is present, and high in WAIT and ACCESS. It is low in DONE and for illegal requests.
- Request is legal when exactly one of REB/WEB is low and Addr[1:0]==0.
- Word index = Addr[DEPTH_LOG2+1:2]. Upper address bits are ignored, so accesses wrap modulo the RAM depth.
- FSM states: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - On a legal request, capture op (read/write), word index and WData.
  - Go to WAIT if WAIT_CYCLES>0 (counter loaded with WAIT_CYCLES-1), else go to ACCESS.
  - On an illegal request, pulse the matching Err output next cycle, perform no access, stay in IDLE.
  - A conflict takes priority; ErrMisalign is not raised together with ErrConflict.
- WAIT: decrement the counter; go to ACCESS when it is 0.
- ACCESS:
  - Write: RAM[idx] <= captured WData.
  - Read: RData <= RAM[idx] and RValid=1 on the following cycle.
  - Next state is DONE.
- DONE:
  - Stall is low, so the pipeline advances one cycle.
  - Return to IDLE unconditionally. A request presented in this cycle is ignored; the pipeline never presents back-to-back requests without a bubble because the advancing instruction carries new enables.
- Latency with W=WAIT_CYCLES:
  - Stall is high for W+2 cycles (IDLE request cycle + W + ACCESS).
  - RValid asserts W+2 cycles after the request cycle.
- Reset mid-operation aborts immediately:
  - A write not yet in ACCESS is never committed.
  - A write in ACCESS is committed only if the clock edge precedes reset assertion.
- Write-then-read to the same address returns the new data, because requests are fully serialised.

Decomposition:
- Shared package dmem_pkg:
  - FSM state encoding (S_IDLE=2'd0, S_WAIT=2'd1, S_ACCESS=2'd2, S_DONE=2'd3)
  - op encoding (OP_RD=1'b0, OP_WR=1'b1)
  - the REB/WEB active-low convention constant
- One sub-module, dmem_ram_sp: single-port synchronous RAM (we, addr, wdata, rdata registered) so the array can be swapped for a vendor macro. The FSM and request capture stay in the top.

Test Plan:
1. Reset: rst=1 mid-WAIT of a write to 0x10, then read 0x10 with RAM preloaded 0xDEADBEEF -> reads 0xDEADBEEF; all outputs 0 during reset.
2. Write/read, W=2: WEB=0, Addr=0x40, WData=0x12345678, then REB=0, Addr=0x40 -> Stall high 4 cycles per request; RData=0x12345678 with RValid one cycle, 4 cycles after the read request.
3. W=0: read Addr=0x0 preloaded 0xA5A5A5A5 -> Stall high 2 cycles; RValid 2 cycles after the request.
4. Wrap: write 0xCAFEF00D to Addr=0x00001000 (DEPTH_LOG2=10) -> read Addr=0x0 returns 0xCAFEF00D.
5. Illegal requests:
   - REB=0 and WEB=0 -> ErrConflict pulses once, Stall stays low, RAM unchanged.
   - Addr=0x42 with WEB=0 -> ErrMisalign pulses, no write.
6. Back-to-back: write 0x1 to 0x8, immediately followed (after the DONE bubble) by a read of 0x8 -> RData=0x1; a request held during DONE is not double-serviced.
